// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM state type, counter-width and saturation-limit helpers for the MAC path.
package mac_pkg;
  typedef enum logic [1:0] {ACC, DRAIN, DONE} state_e;
  function automatic int cnt_w(int n);
    return $clog2(n + 1);
  endfunction
  function automatic longint sat_max(int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic longint sat_min(int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/mac_mult.sv
// mac_mult: registered unsigned-activation x signed-weight product stage.
module mac_mult #(
  parameter int bw = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_i,
  input  logic [bw-1:0]          a_i,
  input  logic [bw-1:0]          b_i,
  output logic signed [2*bw-1:0] prod_o,
  output logic                   valid_o
);
  logic signed [2*bw-1:0] a_x, b_x, prod_d;
  assign a_x = {{bw{1'b0}}, a_i};
  assign b_x = {{bw{b_i[bw-1]}}, b_i};
  // The true product always fits in 2*bw signed bits, so truncation is exact.
  assign prod_d = a_x * b_x;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= load_i;
      if (load_i) prod_o <= prod_d;
    end
  end
endmodule

// File: rtl/mac_stream_acc.sv
// mac_stream_acc: streaming dot-product accumulator; define MAC_SAT_EN for saturating adds (default wraps).
module mac_stream_acc
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int len     = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [bw-1:0]      a,
  input  logic [bw-1:0]      b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] out,
  output logic               busy
);
  localparam int CW = cnt_w(len);
  state_e                     state_q;
  logic [CW-1:0]              count_q;
  logic signed [psum_bw-1:0]  acc_q, acc_d, prod_ext, sum;
  logic signed [2*bw-1:0]     prod;
  logic                       prod_vld, take;
  assign in_ready  = state_q == ACC;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != ACC || count_q != '0;
  assign out       = acc_q;
  assign take      = in_valid && in_ready;
  mac_mult #(.bw(bw)) u_mult (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (take),
    .a_i     (a),
    .b_i     (b),
    .prod_o  (prod),
    .valid_o (prod_vld)
  );
  assign prod_ext = psum_bw'(prod);
  assign sum      = acc_q + prod_ext;
`ifdef MAC_SAT_EN
  logic ovf;
  // Overflow only when both addends share a sign that the sum lost.
  assign ovf   = acc_q[psum_bw-1] == prod_ext[psum_bw-1] && sum[psum_bw-1] != acc_q[psum_bw-1];
  assign acc_d = !ovf ? sum :
                 acc_q[psum_bw-1] ? psum_bw'(sat_min(psum_bw)) : psum_bw'(sat_max(psum_bw));
`else
  assign acc_d = sum;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACC;
      count_q <= '0;
      acc_q   <= '0;
    end else begin
      if (prod_vld) acc_q <= acc_d;
      case (state_q)
        ACC: if (take) begin
          count_q <= count_q + 1'b1;
          if (count_q == CW'(len - 1)) state_q <= DRAIN;
        end
        DRAIN: state_q <= DONE;
        DONE: if (out_ready) begin
          acc_q   <= '0;
          count_q <= '0;
          state_q <= ACC;
        end
        default: state_q <= ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_stream_acc.sv
// tb_mac_stream_acc: table-driven vectors with a result scoreboard, plus stall, reset and narrow-accumulator sequences.
module tb_mac_stream_acc;
  logic        clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, sel2 = 1'b0;
  logic [3:0]  a = '0, b = '0;
  logic        in_ready, out_valid, busy, in_ready2, out_valid2, busy2;
  logic [15:0] out;
  logic [9:0]  out2;
  logic        rdy;
  int          total = 0, bad = 0;
  logic [15:0] q[$];
  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    bit          tog;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  mac_stream_acc dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid && !sel2), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
  );
  mac_stream_acc #(.psum_bw(10)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid && sel2), .in_ready(in_ready2),
    .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready), .out(out2), .busy(busy2)
  );
  assign rdy = sel2 ? in_ready2 : in_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sel2 ? (out_valid2 && out_ready) : (out_valid && out_ready)) begin
      if (q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
      else begin
        logic [15:0] e;
        e = q.pop_front();
        if (sel2) chk("sb_out2", {22'd0, out2}, {22'd0, e[9:0]});
        else chk("sb_out", {16'd0, out}, {16'd0, e});
      end
    end
  end

  task automatic send(input logic [3:0] va, input logic [3:0] vb, input int n, input bit tog);
    int sent = 0, tmo = 0;
    bit ph = 1'b0;
    a = va;
    b = vb;
    while (sent < n && tmo < 300) begin
      in_valid = tog ? !ph : 1'b1;
      @(negedge clk);
      if (in_valid && rdy) sent++;
      @(posedge clk);
      #1;
      tmo++;
      ph = !ph;
    end
    in_valid = 1'b0;
    if (sent < n) chk("send_timeout", 32'(sent), 32'(n));
  endtask

  task automatic wait_done();
    int t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (q.size() != 0) chk("result_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    tbl[0] = '{4'd15, 4'b1000, 1'b0, 16'hFB50};
    tbl[1] = '{4'd2, 4'd7, 1'b1, 16'd140};
    tbl[2] = '{4'd1, 4'hF, 1'b0, 16'hFFF6};
    tbl[3] = '{4'd7, 4'd7, 1'b1, 16'd490};
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    // Latency of the final accept through DRAIN into DONE.
    q.push_back(16'd60);
    send(4'd3, 4'd2, 10, 1'b0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("done_out_valid", 32'(out_valid), 32'd1);
    chk("done_out", 32'(out), 32'h3C);
    @(posedge clk);
    #1;
    chk("after_in_ready", 32'(in_ready), 32'd1);
    chk("after_out_valid", 32'(out_valid), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
    wait_done();
    for (int i = 0; i < 4; i++) begin
      q.push_back(tbl[i].exp);
      send(tbl[i].a, tbl[i].b, 10, tbl[i].tog);
      wait_done();
    end
    // Consumer stall with in_valid held high: nothing may be accepted.
    out_ready = 1'b0;
    q.push_back(16'h0078);
    send(4'd4, 4'd3, 10, 1'b0);
    for (int t = 0; t < 10 && !out_valid; t++) begin
      @(posedge clk);
      #1;
    end
    a = 4'd9;
    in_valid = 1'b1;
    for (int t = 0; t < 5; t++) begin
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out", 32'(out), 32'h78);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_done();
    @(posedge clk);
    #1;
    chk("stall_clear_out", 32'(out), 32'd0);
    q.push_back(16'hFFF6);
    send(4'd1, 4'hF, 10, 1'b0);
    wait_done();
    // Reset mid-vector discards partial work.
    send(4'd5, 4'd5, 4, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out", 32'(out), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    q.push_back(16'd10);
    send(4'd1, 4'd1, 10, 1'b0);
    wait_done();
    // Narrow accumulator: 10 x 105 overflows a 10-bit signed range.
    sel2 = 1'b1;
`ifdef MAC_SAT_EN
    q.push_back(16'd511);
`else
    q.push_back(16'd26);
`endif
    send(4'd15, 4'd7, 10, 1'b0);
    wait_done();
    sel2 = 1'b0;
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mac_stream_acc.md
# mac_stream_acc

Operand-consuming end of the MAC data path. Accepts a stream of (activation, weight) pairs over a valid/ready handshake, multiplies each unsigned activation by its signed weight, and accumulates the products in a partial-sum register. After `len` pairs it presents the dot-product over a second valid/ready handshake, then clears and waits for the next vector. It sits between the operand feeders (activation/weight buffers) and the psum collector.

## Interface

- `bw`, 4, operand width (activation and weight)
- `psum_bw`, 16, accumulator/output width; must be ≥ 2*`bw`
- `len`, 10, pairs per vector; ≥ 1
- `clk`  input  1  rising-edge clock
- `reset_n`  input  1  asynchronous, active-low reset
- `in_valid`  input  1  operand pair valid
- `in_ready`  output  1  block can accept a pair
- `a`  input  `bw`  activation, unsigned
- `b`  input  `bw`  weight, two's-complement signed
- `out_valid`  output  1  `out` holds a completed dot-product
- `out_ready`  input  1  consumer takes `out`
- `out`  output  `psum_bw`  accumulated result, two's-complement signed
- `busy`  output  1  state ≠ ACC or count ≠ 0

## Operation

- States: ACC, DRAIN, DONE. Reset: state ACC, count 0, acc 0, product stage empty; outputs in_ready=1, out_valid=0, out=0, busy=0. No transfer is counted while reset_n is low.
- ACC: in_ready=1. Transfer when in_valid && in_ready at a rising edge. Each transfer loads the product stage and increments count. On the `len`-th transfer, go to DRAIN, in_ready=0.
- Product stage: a zero-extended to `bw`+1 bits, times b sign-extended; result held in 2*`bw` signed bits (no overflow possible). Product sign-extended to `psum_bw`, added to acc one cycle after capture.
- DRAIN: one cycle; last product lands in acc; go to DONE.
- DONE: out_valid=1, out=acc, stable until out_valid && out_ready. On that edge: acc←0, count←0, state←ACC. No new pair is accepted in the same cycle as the output handshake.
- Default add: wrap modulo 2^`psum_bw`.
- out is driven from acc at all times; only meaningful while out_valid=1.
- reset_n low at any point (mid-vector, DRAIN, DONE) discards everything and returns to reset values immediately.

## Timing

- Pair accepted at edge T → product registered at T → acc updated at T+1.
- Last pair accepted at edge T → DRAIN during cycle after T → out_valid high after edge T+1.
- Minimum vector period: `len` + 2 cycles (len accepts, DRAIN, one DONE cycle with out_ready=1).
- in_ready and out_valid are decoded from registered state only; no combinational path from in_valid or out_ready to any output.
- Gaps on in_valid stall the count; no time-out.

## Configuration

- `MAC_SAT_EN` defined: each add saturates to [−2^(`psum_bw`−1), 2^(`psum_bw`−1)−1]; once saturated, further opposite-sign products move acc back off the rail normally.
- `MAC_SAT_EN` undefined: wrap-around add, no saturation logic.

## Structure

- Shared package `mac_pkg`: state enum (ACC, DRAIN, DONE), a count-width helper function (clog2 of `len`+1), and the saturation-limit helper functions.
- One sub-module: `mac_mult`, registered unsigned×signed multiplier stage (a, b, load enable → registered 2*`bw` product + valid).
- Top holds the FSM, the counter, the accumulator and the saturation/wrap adder.

## Test plan

- Default params, 10 pairs a=3, b=2, in_valid held high, out_ready=1 → out_valid 2 cycles after last accept, out=60 (0x003C), in_ready back to 1 next cycle.
- 10 pairs a=15, b=−8 (4'b1000) → out=−1200 (0xFB50); confirms unsigned×signed extension.
- Vector completes, out_ready held low 5 cycles → out_valid and out stable, in_ready=0 throughout; out_ready high → cleared, next vector of 10 × (a=1, b=−1) gives 0xFFF6.
- in_valid toggled 1-0-1-0 over 10 pairs a=2, b=7 → no extra or missing counts, out=140.
- reset_n pulsed low after 4 pairs of (a=5, b=5), then 10 pairs a=1, b=1 → out=10; the first 4 pairs are not included.
- psum_bw=10, 10 pairs a=15, b=7 → without `MAC_SAT_EN` out=26 (1050 mod 1024); with `MAC_SAT_EN` out=511.
